// File: rtl/edge_event_unit.sv
// Multi-channel edge-event detector: sync chain, optional debounce, edge qualify,
// sticky pending with write-1-to-clear, irq summary, saturating event count.
// Build option: define EDGE_DEBOUNCE_EN to compile in the per-channel debounce filter.
module edge_event_unit #(
  parameter int N               = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     din,
  input  logic [2*N-1:0]   mode,
  input  logic [N-1:0]     clr,
  input  logic             clr_cnt,
  output logic [N-1:0]     pulse,
  output logic [N-1:0]     pending,
  output logic             irq,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int SW = CNT_W + 7;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || N < 1 || N > 32)
  begin : g_bad_cfg
    $error("edge_event_unit: parameter out of range");
  end

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0] sync_out;
  logic [N-1:0] lvl;
  logic [N-1:0] diff;
  logic [N-1:0] accept;
  logic [N-1:0] lvl_nxt;
  logic [N-1:0] pulse_nxt;
  logic [N-1:0] pending_nxt;
  logic [SW-1:0] sum;
  logic [SW-1:0] tot;
  logic [SW-1:0] cnt_max;
  logic [CNT_W-1:0] cnt_nxt;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign diff     = sync_out ^ lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0][DW-1:0] db_q;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = diff[i] && (db_q[i] == DB_LAST);
    end
  end

  // Run length of the disagreeing level; any agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!diff[i] || accept[i]) begin
          db_q[i] <= '0;
        end else begin
          db_q[i] <= db_q[i] + DW'(1);
        end
      end
    end
  end
`else
  assign accept = diff;
`endif

  always_comb begin
    pulse_nxt = '0;
    for (int i = 0; i < N; i++) begin
      pulse_nxt[i] = accept[i] &&
        (sync_out[i] ? mode[2*i] : mode[2*i+1]);
    end
  end

  assign lvl_nxt     = (lvl & ~accept) | (sync_out & accept);
  assign pending_nxt = pulse_nxt | (pending & ~clr);

  always_comb begin
    cnt_max = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};
    sum     = SW'($countones(pulse_nxt));
    tot     = sum;
    if (!clr_cnt) begin
      tot = sum + {{(SW-CNT_W){1'b0}}, evt_cnt};
    end
    cnt_nxt = tot[CNT_W-1:0];
    if (tot > cnt_max) begin
      cnt_nxt = {CNT_W{1'b1}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl     <= '0;
      pulse   <= '0;
      pending <= '0;
      irq     <= 1'b0;
      evt_cnt <= '0;
    end else begin
      lvl     <= lvl_nxt;
      pulse   <= pulse_nxt;
      pending <= pending_nxt;
      irq     <= |pending_nxt;
      evt_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_unit.sv
// Self-checking bench for edge_event_unit: directed scenarios plus random
// traffic against a sample-history reference model.
module tb_edge_event_unit;

  localparam int N    = 8;
  localparam int SS   = 2;
  localparam int DC   = 4;
  localparam int CW   = 8;
`ifdef EDGE_DEBOUNCE_EN
  localparam bit DB   = 1'b1;
`else
  localparam bit DB   = 1'b0;
`endif
  localparam int LAT  = DB ? SS + DC - 1 : SS;
  localparam int HOLD = DB ? DC : 1;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] din = '0;
  logic [2*N-1:0] mode = '0;
  logic [N-1:0] clr = '0;
  logic clr_cnt = 1'b0;
  logic [N-1:0] pulse;
  logic [N-1:0] pending;
  logic irq;
  logic [CW-1:0] evt_cnt;

  edge_event_unit #(
    .N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
    .clr_cnt(clr_cnt), .pulse(pulse), .pending(pending),
    .irq(irq), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] hist[$];
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_pulse;
  logic [N-1:0] m_pend;
  int m_run[N];
  int m_cnt;
  logic [2*N+CW:0] obs, exp;

  function automatic void model_reset();
    hist.delete();
    for (int s = 0; s < SS; s++) hist.push_back('0);
    m_lvl = '0;
    m_pulse = '0;
    m_pend = '0;
    m_cnt = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endfunction

  // One clock edge of the reference: the level seen by the edge logic is the
  // din sample taken SS edges earlier; a new level is taken once it has
  // disagreed for DC consecutive edges (or immediately without debounce).
  function automatic void model_edge();
    logic [N-1:0] s;
    logic [N-1:0] np;
    int fires;
    s = hist[SS-1];
    np = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (!DB || m_run[i] >= DC) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
          np[i] = s[i] ? mode[2*i] : mode[2*i+1];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pend = np | (m_pend & ~clr);
    fires = $countones(np);
    m_cnt = clr_cnt ? fires : m_cnt + fires;
    if (m_cnt > MAXC) m_cnt = MAXC;
    m_pulse = np;
    hist.push_front(din);
    void'(hist.pop_back());
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    obs = {pulse, pending, irq, evt_cnt};
    exp = {m_pulse, m_pend, |m_pend, CW'(m_cnt)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (pulse !== '0) begin
      n_bad++; $display("FAIL reset_pulse: got %h want 0", pulse);
    end
    n_cmp++;
    if (pending !== '0) begin
      n_bad++; $display("FAIL reset_pending: got %h want 0", pending);
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    n_cmp++;
    if (evt_cnt !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", evt_cnt);
    end
    din = '0;
    rst = 1'b0;
  endtask

  task automatic test_rise();
    mode = {N{2'b01}};
    din[0] = 1'b1;
    for (int k = 0; k <= LAT + 2; k++) begin
      step();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL rise_model k%0d: got %h want %h", k, obs, exp);
      end
      n_cmp++;
      if (pulse[0] !== (k == LAT)) begin
        n_bad++; $display("FAIL rise_lat k%0d: got %b want %b", k, pulse[0], k == LAT);
      end
    end
    n_cmp++;
    if ({irq, pending[0], evt_cnt} !== {1'b1, 1'b1, CW'(1)}) begin
      n_bad++; $display("FAIL rise_state: got irq=%b pend=%b cnt=%0d want 1 1 1",
                        irq, pending[0], evt_cnt);
    end
    din[0] = 1'b0;
    for (int k = 0; k <= LAT + 2; k++) begin
      step();
      n_cmp++;
      if (pulse !== '0 || obs !== exp) begin
        n_bad++; $display("FAIL fall_ignored k%0d: got %h want %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_modes();
    int p1, p2, c0;
    mode = '0;
    mode[3:2] = 2'b11;
    mode[5:4] = 2'b10;
    p1 = 0; p2 = 0;
    c0 = m_cnt;
    for (int ph = 0; ph < 2; ph++) begin
      din[2:1] = (ph == 0) ? 2'b11 : 2'b00;
      for (int k = 0; k <= LAT + 2; k++) begin
        step();
        p1 += int'(pulse[1]);
        p2 += int'(pulse[2]);
        n_cmp++;
        if (obs !== exp) begin
          n_bad++; $display("FAIL modes ph%0d k%0d: got %h want %h", ph, k, obs, exp);
        end
      end
    end
    n_cmp++;
    if (p1 != 2 || p2 != 1) begin
      n_bad++; $display("FAIL modes_count: got p1=%0d p2=%0d want 2 1", p1, p2);
    end
    n_cmp++;
    if (int'(evt_cnt) != c0 + 3) begin
      n_bad++; $display("FAIL modes_cnt: got %0d want %0d", evt_cnt, c0 + 3);
    end
  endtask

  task automatic test_glitch();
    int p3;
    mode = {N{2'b11}};
    p3 = 0;
    din[3] = 1'b1;
    repeat (HOLD == 1 ? 1 : DC - 1) begin
      step(); p3 += int'(pulse[3]);
    end
    din[3] = 1'b0;
    for (int k = 0; k <= LAT + 3; k++) begin
      step();
      p3 += int'(pulse[3]);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL glitch k%0d: got %h want %h", k, obs, exp);
      end
    end
`ifdef EDGE_DEBOUNCE_EN
    n_cmp++;
    if (p3 != 0) begin
      n_bad++; $display("FAIL glitch_filtered: got %0d pulses want 0", p3);
    end
    din[3] = 1'b1;
    for (int k = 0; k <= LAT + 1; k++) begin
      step();
      n_cmp++;
      if (pulse[3] !== (k == LAT)) begin
        n_bad++; $display("FAIL hold_lat k%0d: got %b want %b", k, pulse[3], k == LAT);
      end
    end
    din[3] = 1'b0;
    repeat (LAT + 2) step();
`else
    n_cmp++;
    if (p3 != 2) begin
      n_bad++; $display("FAIL glitch_pulses: got %0d want 2", p3);
    end
`endif
  endtask

  task automatic test_clr_collision();
    mode = {N{2'b11}};
    clr = '1;
    step();
    clr = '0;
    n_cmp++;
    if (pending !== '0 || irq !== 1'b0) begin
      n_bad++; $display("FAIL clr_all: got pend=%h irq=%b want 0 0", pending, irq);
    end
    din[4] = ~din[4];
    repeat (LAT + 1) step();
    din[4] = ~din[4];
    repeat (LAT) step();
    clr[4] = 1'b1;
    step();
    n_cmp++;
    if ({pulse[4], pending[4], irq} !== 3'b111 || obs !== exp) begin
      n_bad++; $display("FAIL set_wins: got %h want %h", obs, exp);
    end
    step();
    clr[4] = 1'b0;
    n_cmp++;
    if ({pending[4], irq} !== 2'b00 || obs !== exp) begin
      n_bad++; $display("FAIL clr_alone: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_saturation();
    mode = {N{2'b11}};
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int t = 0; t < 40; t++) begin
      din = ~din;
      repeat (HOLD) begin
        step();
        n_cmp++;
        if (obs !== exp) begin
          n_bad++; $display("FAIL sat t%0d: got %h want %h", t, obs, exp);
        end
      end
    end
    repeat (LAT + 2) step();
    n_cmp++;
    if (evt_cnt !== CW'(MAXC)) begin
      n_bad++; $display("FAIL sat_cap: got %0d want %0d", evt_cnt, MAXC);
    end
    din[1:0] = ~din[1:0];
    repeat (LAT) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_cmp++;
    if (evt_cnt !== CW'(2) || obs !== exp) begin
      n_bad++; $display("FAIL clr_cnt_evt: got cnt=%0d want 2", evt_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) din = N'($urandom);
      if ($urandom_range(0, 15) == 0) mode = (2*N)'($urandom);
      clr = N'($urandom & $urandom & $urandom);
      clr_cnt = ($urandom_range(0, 31) == 0);
      step();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL random t%0d: got %h want %h", t, obs, exp);
      end
    end
    clr = '0;
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode = {N{2'b01}};
    din = '0;
    repeat (LAT + 2) step();
    din = '1;
    repeat (LAT - 1) step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pulse, pending, irq, evt_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_mid: got %h want 0", {pulse, pending, irq, evt_cnt});
    end
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      step();
      n_cmp++;
      if (pulse !== ((k == LAT) ? {N{1'b1}} : {N{1'b0}}) || obs !== exp) begin
        n_bad++; $display("FAIL reset_relat k%0d: got %h want %h", k, obs, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_modes();
    test_glitch();
    test_clr_collision();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
